// File: rtl/mrc_pkg.sv
// Shared definitions for the MRC command sequencer: FSM states, op encodings
// and the default operand width.
package mrc_pkg;

  localparam int unsigned DEFAULT_WORD_LENGTH = 16;

  localparam logic OP_TWO = 1'b0;
  localparam logic OP_ONE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_X,
    ST_LOAD_X,
    ST_WAIT_Y,
    ST_LOAD_Y,
    ST_WAIT_DONE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mrc_sequencer_if.sv
// Host-side command and response streams of the MRC sequencer.
interface mrc_sequencer_if #(
  parameter int unsigned WORD_LENGTH = mrc_pkg::DEFAULT_WORD_LENGTH
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_op;
  logic [WORD_LENGTH-1:0]   cmd_a;
  logic [WORD_LENGTH-1:0]   cmd_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [2*WORD_LENGTH-1:0] rsp_result;
  logic                     rsp_error;
  logic                     rsp_timeout;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_error, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_error, rsp_timeout
  );

endinterface

// File: rtl/mrc_timeout_ctr.sv
// Wait-state watchdog: counts cycles while enabled and flags the last allowed
// cycle so the FSM can abort on the following edge.
module mrc_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // hit is registered alongside cnt so it is true while cnt == TIMEOUT_CYCLES-1
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hit <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      hit <= (TIMEOUT_CYCLES == 1);
    end else if (enable) begin
      cnt <= CW'(cnt + 1'b1);
      hit <= (CW'(cnt + 1'b1) == CW'(TIMEOUT_CYCLES - 1));
    end
  end

endmodule

// File: rtl/mrc_sequencer.sv
// Drives the MRC start/load/ready protocol for one host command at a time and
// returns the captured result, error or timeout on the response stream.
module mrc_sequencer
  import mrc_pkg::*;
#(
  parameter int unsigned WORD_LENGTH    = DEFAULT_WORD_LENGTH,
  parameter int unsigned START_CYCLES   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  mrc_sequencer_if.slave           host,
  output logic                     mrc_start,
  output logic                     mrc_load,
  output logic                     mrc_op,
  output logic [WORD_LENGTH-1:0]   mrc_data,
  input  logic                     mrc_ready,
  input  logic [2*WORD_LENGTH-1:0] mrc_result,
  input  logic                     mrc_x,
  input  logic                     mrc_y,
  input  logic                     mrc_error
);

  localparam int unsigned SW = $clog2(START_CYCLES + 1);

  state_e                 state;
  state_e                 next_state;
  logic [SW-1:0]          start_cnt;
  logic                   op_q;
  logic [WORD_LENGTH-1:0] a_q;
  logic [WORD_LENGTH-1:0] b_q;

  logic accept_c;
  logic done_c;
  logic abort_c;
  logic in_wait_c;
  logic to_hit;

  mrc_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait_c),
    .enable (in_wait_c),
    .hit    (to_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Awaited flag wins over timeout in the same cycle.
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    done_c     = 1'b0;
    abort_c    = 1'b0;
    in_wait_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (host.cmd_valid && host.cmd_ready) begin
          accept_c   = 1'b1;
          next_state = ST_START;
        end
      end
      ST_START: begin
        if (start_cnt == SW'(START_CYCLES - 1)) next_state = ST_WAIT_X;
      end
      ST_WAIT_X: begin
        in_wait_c = 1'b1;
        if (mrc_x) begin
          next_state = ST_LOAD_X;
        end else if (to_hit) begin
          abort_c    = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_LOAD_X: begin
        next_state = (op_q == OP_ONE) ? ST_WAIT_DONE : ST_WAIT_Y;
      end
      ST_WAIT_Y: begin
        in_wait_c = 1'b1;
        if (mrc_y) begin
          next_state = ST_LOAD_Y;
        end else if (to_hit) begin
          abort_c    = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_LOAD_Y: begin
        next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        in_wait_c = 1'b1;
        if (mrc_ready) begin
          done_c     = 1'b1;
          next_state = ST_RESP;
        end else if (to_hit) begin
          abort_c    = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (host.rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_cnt        <= '0;
      op_q             <= 1'b0;
      a_q              <= '0;
      b_q              <= '0;
      host.cmd_ready   <= 1'b0;
      host.rsp_valid   <= 1'b0;
      host.rsp_result  <= '0;
      host.rsp_error   <= 1'b0;
      host.rsp_timeout <= 1'b0;
      mrc_start        <= 1'b0;
      mrc_load         <= 1'b0;
      mrc_op           <= 1'b0;
      mrc_data         <= '0;
    end else begin
      start_cnt <= (state == ST_START) ? SW'(start_cnt + 1'b1) : '0;

      if (accept_c) begin
        op_q <= host.cmd_op;
        a_q  <= host.cmd_a;
        b_q  <= host.cmd_b;
      end

      host.cmd_ready <= (next_state == ST_IDLE);
      host.rsp_valid <= (next_state == ST_RESP);
      mrc_start      <= (next_state == ST_START);
      mrc_load       <= (next_state == ST_LOAD_X) || (next_state == ST_LOAD_Y);
      mrc_op         <= (next_state == ST_IDLE) ? 1'b0 : (accept_c ? host.cmd_op : op_q);

      if (next_state == ST_LOAD_X)      mrc_data <= a_q;
      else if (next_state == ST_LOAD_Y) mrc_data <= b_q;

      if (done_c) begin
        host.rsp_result  <= mrc_result;
        host.rsp_error   <= mrc_error;
        host.rsp_timeout <= 1'b0;
      end else if (abort_c) begin
        host.rsp_result  <= '0;
        host.rsp_error   <= 1'b0;
        host.rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mrc_sequencer.sv
// Directed bench for mrc_sequencer; the MRC side is driven by hand per scenario.
module tb_mrc_sequencer;

  localparam int unsigned WL = 16;
  localparam int unsigned SC = 3;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mrc_start, mrc_load, mrc_op;
  logic [WL-1:0] mrc_data;
  logic          mrc_ready = 1'b0;
  logic [2*WL-1:0] mrc_result = '0;
  logic          mrc_x = 1'b0, mrc_y = 1'b0, mrc_error = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int            n_loads = 0;
  logic [WL-1:0] load_data[$];
  int            load_cyc[$];
  int            start_len = 0;
  int            start_first = -1;
  logic          start_prev = 1'b0;
  int            overlap = 0;

  mrc_sequencer_if #(.WORD_LENGTH(WL)) host ();

  mrc_sequencer #(
    .WORD_LENGTH(WL), .START_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .host(host),
    .mrc_start(mrc_start), .mrc_load(mrc_load), .mrc_op(mrc_op), .mrc_data(mrc_data),
    .mrc_ready(mrc_ready), .mrc_result(mrc_result), .mrc_x(mrc_x), .mrc_y(mrc_y),
    .mrc_error(mrc_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cumulative record of MRC-side activity; tests work from snapshots.
  always @(negedge clk) begin
    if (mrc_load === 1'b1) begin
      n_loads++;
      load_data.push_back(mrc_data);
      load_cyc.push_back(cyc);
    end
    if (mrc_start === 1'b1 && start_prev !== 1'b1) start_first = cyc;
    if (mrc_start === 1'b1) start_len++;
    start_prev = mrc_start;
    if (host.cmd_ready === 1'b1 && host.rsp_valid === 1'b1) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_cmd(input logic op, input logic [WL-1:0] a, input logic [WL-1:0] b);
    int n = 0;
    host.cmd_op = op; host.cmd_a = a; host.cmd_b = b; host.cmd_valid = 1'b1;
    while (host.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (host.cmd_ready !== 1'b1) begin
      n_cmp++; n_bad++; $display("FAIL cmd_accept: cmd_ready=%b, required 1", host.cmd_ready);
    end
    @(negedge clk);
    host.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int c);
    int n = 0;
    while (host.rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    c = cyc;
    if (host.rsp_valid !== 1'b1) begin
      n_cmp++; n_bad++; $display("FAIL rsp_wait: rsp_valid=%b, required 1", host.rsp_valid);
    end
  endtask

  task automatic wait_load(input logic [WL-1:0] d, output int c);
    int n = 0;
    while (!(mrc_load === 1'b1 && mrc_data === d) && n < 40) begin @(negedge clk); n++; end
    c = cyc;
    if (mrc_load !== 1'b1) begin
      n_cmp++; n_bad++; $display("FAIL load_wait: mrc_load=%b data=%0d, required load of %0d", mrc_load, mrc_data, d);
    end
  endtask

  task automatic release_rsp();
    host.rsp_ready = 1'b1;
    @(negedge clk);
    host.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (host.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 0", host.cmd_ready); end
    n_cmp++; if (host.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", host.rsp_valid); end
    n_cmp++; if ({host.rsp_result, host.rsp_error, host.rsp_timeout} !== 34'd0) begin n_bad++;
      $display("FAIL rst_rsp_payload: got %0h/%b/%b want 0/0/0", host.rsp_result, host.rsp_error, host.rsp_timeout); end
    n_cmp++; if ({mrc_start, mrc_load, mrc_op} !== 3'b000) begin n_bad++;
      $display("FAIL rst_mrc_ctrl: got start/load/op %b%b%b want 000", mrc_start, mrc_load, mrc_op); end
    n_cmp++; if (mrc_data !== 16'd0) begin n_bad++; $display("FAIL rst_mrc_data: got %0d want 0", mrc_data); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (host.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", host.cmd_ready); end
  endtask

  task automatic test_two_op();
    int lb, sb, rc;
    mrc_x = 1; mrc_y = 1; mrc_ready = 1; mrc_error = 0; mrc_result = 32'd49161;
    lb = n_loads; sb = start_len;
    do_cmd(1'b0, 16'd16387, 16'd3);
    wait_rsp(rc);
    n_cmp++; if (n_loads - lb !== 2) begin n_bad++; $display("FAIL two_load_count: got %0d want 2", n_loads - lb); end
    n_cmp++; if (load_data[lb] !== 16'd16387) begin n_bad++; $display("FAIL two_load_x: got %0d want 16387", load_data[lb]); end
    n_cmp++; if (load_data[lb+1] !== 16'd3) begin n_bad++; $display("FAIL two_load_y: got %0d want 3", load_data[lb+1]); end
    n_cmp++; if (start_len - sb !== SC) begin n_bad++; $display("FAIL two_start_len: got %0d want %0d", start_len - sb, SC); end
    n_cmp++; if (load_cyc[lb] - start_first !== SC + 1) begin n_bad++;
      $display("FAIL two_load_x_time: got %0d want %0d", load_cyc[lb] - start_first, SC + 1); end
    n_cmp++; if (load_cyc[lb+1] - load_cyc[lb] !== 2) begin n_bad++;
      $display("FAIL two_load_gap: got %0d want 2", load_cyc[lb+1] - load_cyc[lb]); end
    n_cmp++; if (rc - start_first !== SC + 5) begin n_bad++; $display("FAIL two_latency: got %0d want %0d", rc - start_first, SC + 5); end
    n_cmp++; if (host.rsp_result !== 32'd49161) begin n_bad++; $display("FAIL two_result: got %0d want 49161", host.rsp_result); end
    n_cmp++; if ({host.rsp_error, host.rsp_timeout} !== 2'b00) begin n_bad++;
      $display("FAIL two_flags: got err/to %b%b want 00", host.rsp_error, host.rsp_timeout); end
    n_cmp++; if (mrc_op !== 1'b0) begin n_bad++; $display("FAIL two_mrc_op: got %b want 0", mrc_op); end
    release_rsp();
    n_cmp++; if ({host.rsp_valid, host.cmd_ready} !== 2'b01) begin n_bad++;
      $display("FAIL two_return_idle: got valid/ready %b%b want 01", host.rsp_valid, host.cmd_ready); end
    n_cmp++; if (mrc_data !== 16'd3) begin n_bad++; $display("FAIL two_data_hold: got %0d want 3", mrc_data); end
  endtask

  task automatic test_one_op();
    int lb, lc;
    mrc_x = 1; mrc_y = 0; mrc_ready = 0; mrc_error = 0; mrc_result = 32'hCAFE0042;
    lb = n_loads;
    do_cmd(1'b1, 16'd16387, 16'hFFFF);
    wait_load(16'd16387, lc);
    repeat (3) @(negedge clk);
    n_cmp++; if (host.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL one_early_rsp: got %b want 0", host.rsp_valid); end
    n_cmp++; if (mrc_op !== 1'b1) begin n_bad++; $display("FAIL one_mrc_op: got %b want 1", mrc_op); end
    mrc_ready = 1;
    @(negedge clk);
    n_cmp++; if (host.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL one_ready_to_valid: got %b want 1", host.rsp_valid); end
    n_cmp++; if (host.rsp_result !== 32'hCAFE0042) begin n_bad++; $display("FAIL one_result: got %0h want cafe0042", host.rsp_result); end
    n_cmp++; if (n_loads - lb !== 1) begin n_bad++; $display("FAIL one_load_count: got %0d want 1", n_loads - lb); end
    release_rsp();
  endtask

  task automatic test_error_ignored();
    int lc;
    mrc_x = 1; mrc_y = 1; mrc_ready = 0; mrc_error = 1; mrc_result = 32'hDEADBEEF;
    do_cmd(1'b0, 16'd5, 16'd7);
    wait_load(16'd7, lc);
    mrc_error = 0;
    repeat (2) @(negedge clk);
    mrc_ready = 1;
    @(negedge clk);
    n_cmp++; if (host.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL errign_valid: got %b want 1", host.rsp_valid); end
    n_cmp++; if ({host.rsp_error, host.rsp_timeout} !== 2'b00) begin n_bad++;
      $display("FAIL errign_flags: got err/to %b%b want 00", host.rsp_error, host.rsp_timeout); end
    n_cmp++; if (host.rsp_result !== 32'hDEADBEEF) begin n_bad++; $display("FAIL errign_result: got %0h want deadbeef", host.rsp_result); end
    release_rsp();
  endtask

  task automatic test_error_ready();
    int lb, rc;
    mrc_x = 1; mrc_y = 0; mrc_ready = 1; mrc_error = 1; mrc_result = 32'h00012345;
    lb = n_loads;
    do_cmd(1'b1, 16'd16387, 16'd0);
    wait_rsp(rc);
    n_cmp++; if (rc - start_first !== SC + 3) begin n_bad++; $display("FAIL err_latency: got %0d want %0d", rc - start_first, SC + 3); end
    n_cmp++; if ({host.rsp_error, host.rsp_timeout} !== 2'b10) begin n_bad++;
      $display("FAIL err_flags: got err/to %b%b want 10", host.rsp_error, host.rsp_timeout); end
    n_cmp++; if (host.rsp_result !== 32'h00012345) begin n_bad++; $display("FAIL err_result: got %0h want 12345", host.rsp_result); end
    n_cmp++; if (n_loads - lb !== 1) begin n_bad++; $display("FAIL err_load_count: got %0d want 1", n_loads - lb); end
    release_rsp();
  endtask

  task automatic test_timeout();
    int lb, lc, rc;
    mrc_x = 1; mrc_y = 0; mrc_ready = 0; mrc_error = 1; mrc_result = 32'hFFFFFFFF;
    lb = n_loads;
    do_cmd(1'b0, 16'd100, 16'd200);
    wait_load(16'd100, lc);
    wait_rsp(rc);
    // WAIT_Y is entered the cycle after the X strobe.
    n_cmp++; if (rc - (lc + 1) !== TO) begin n_bad++; $display("FAIL to_time: got %0d want %0d", rc - (lc + 1), TO); end
    n_cmp++; if ({host.rsp_error, host.rsp_timeout} !== 2'b01) begin n_bad++;
      $display("FAIL to_flags: got err/to %b%b want 01", host.rsp_error, host.rsp_timeout); end
    n_cmp++; if (host.rsp_result !== 32'd0) begin n_bad++; $display("FAIL to_result: got %0h want 0", host.rsp_result); end
    n_cmp++; if (n_loads - lb !== 1) begin n_bad++; $display("FAIL to_load_count: got %0d want 1", n_loads - lb); end
    release_rsp();
  endtask

  task automatic test_backpressure();
    int sb, rc;
    mrc_x = 1; mrc_y = 1; mrc_ready = 1; mrc_error = 0; mrc_result = 32'h00001111;
    sb = start_len;
    do_cmd(1'b0, 16'h0A0A, 16'h0B0B);
    wait_rsp(rc);
    host.cmd_valid = 1'b1; host.cmd_op = 1'b1; host.cmd_a = 16'h5555;
    mrc_result = 32'h22222222; mrc_error = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (!(host.rsp_valid === 1'b1 && host.rsp_result === 32'h00001111 && host.rsp_error === 1'b0 &&
            host.rsp_timeout === 1'b0 && host.cmd_ready === 1'b0)) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b res=%0h err=%b to=%b cmd_ready=%b want 1/1111/0/0/0", i,
                 host.rsp_valid, host.rsp_result, host.rsp_error, host.rsp_timeout, host.cmd_ready);
      end
    end
    host.cmd_valid = 1'b0;
    n_cmp++; if (start_len - sb !== SC) begin n_bad++; $display("FAIL bp_no_second_start: got %0d want %0d", start_len - sb, SC); end
    release_rsp();
    n_cmp++; if ({host.rsp_valid, host.cmd_ready} !== 2'b01) begin n_bad++;
      $display("FAIL bp_return_idle: got valid/ready %b%b want 01", host.rsp_valid, host.cmd_ready); end
    repeat (3) @(negedge clk);
    n_cmp++; if (mrc_start !== 1'b0) begin n_bad++; $display("FAIL bp_stale_cmd: got mrc_start %b want 0", mrc_start); end
  endtask

  task automatic test_reset_mid();
    int lb, lc, rc;
    mrc_x = 1; mrc_y = 1; mrc_ready = 0; mrc_error = 0; mrc_result = 32'd49161;
    do_cmd(1'b0, 16'h1234, 16'h5678);
    wait_load(16'h5678, lc);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mrc_start, mrc_load, host.rsp_valid, host.cmd_ready} !== 4'b0000) begin n_bad++;
      $display("FAIL mid_rst_outputs: got start/load/valid/ready %b%b%b%b want 0000", mrc_start, mrc_load, host.rsp_valid, host.cmd_ready); end
    n_cmp++; if ({mrc_data, mrc_op} !== 17'd0) begin n_bad++; $display("FAIL mid_rst_data: got data=%0h op=%b want 0/0", mrc_data, mrc_op); end
    reset = 1'b0; mrc_ready = 1;
    @(negedge clk);
    n_cmp++; if ({host.rsp_valid, host.cmd_ready} !== 2'b01) begin n_bad++;
      $display("FAIL mid_release: got valid/ready %b%b want 01", host.rsp_valid, host.cmd_ready); end
    repeat (3) @(negedge clk);
    n_cmp++; if (host.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_dropped: got rsp_valid %b want 0", host.rsp_valid); end
    mrc_y = 0; mrc_result = 32'd777;
    lb = n_loads;
    do_cmd(1'b1, 16'd42, 16'd0);
    wait_rsp(rc);
    n_cmp++; if (host.rsp_result !== 32'd777) begin n_bad++; $display("FAIL mid_fresh_result: got %0d want 777", host.rsp_result); end
    n_cmp++; if (n_loads - lb !== 1 || load_data[lb] !== 16'd42) begin n_bad++;
      $display("FAIL mid_fresh_load: got %0d loads, first %0d, want 1 load of 42", n_loads - lb, load_data[lb]); end
    release_rsp();
  endtask

  initial begin
    host.cmd_valid = 1'b0; host.cmd_op = 1'b0; host.cmd_a = '0; host.cmd_b = '0; host.rsp_ready = 1'b0;
    test_reset();
    test_two_op();
    test_one_op();
    test_error_ignored();
    test_error_ready();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL ready_valid_overlap: got %0d cycles want 0", overlap); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
